square_period_meter: RTL and testbench
======================================

// Module: square_period_meter
// PURPOSE
//  Downstream consumer of the square-wave generator output. Measures the period and high
//  time of an incoming square wave, in clk cycles, and reports each completed period with
//  a one-cycle valid strobe. Flags loss of signal (no rising edge within TIMEOUT cycles).
//  Used to confirm divider outputs, e.g. a 512/512 toggle reads period=1024, high=512.
// PARAMETERS
//  CNT_W        16      width of period/high_time counters and outputs
//  TIMEOUT      65535   cycles without a rising edge before timeout; 2 <= TIMEOUT <= 2**CNT_W-1
//  SYNC_STAGES  2       flops in the sig_in synchronizer (>=2)
// PORTS
//  clk         in   1      single clock; all logic on posedge clk
//  rst         in   1      asynchronous, active-high reset
//  sig_in      in   1      square wave to measure, asynchronous to clk
//  period      out  CNT_W  cycles between last two rising edges; held until next update
//  high_time   out  CNT_W  cycles sig was high within that period; updated with period
//  meas_valid  out  1      one-cycle pulse: period/high_time updated this cycle
//  locked      out  1      high once >=1 full period measured and no timeout since
//  timeout     out  1      one-cycle pulse when TIMEOUT expires in MEASURE
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, counters 0, synchronizer 0, state IDLE.
//  Synchronizer: sig_in -> SYNC_STAGES flops -> s; plus one prev flop s_d.
//   rise = s & ~s_d; fall = ~s & s_d. Edge seen SYNC_STAGES+1 cycles after sig_in changes.
//  Counter cnt: on rise cnt <= 1; else in MEASURE cnt <= cnt+1, saturating at TIMEOUT.
//   Thus cnt = k on the k-th cycle after the rise cycle.
//  FSM states: IDLE, MEASURE.
//   IDLE: cnt held 0. On rise -> MEASURE, cnt <= 1. No meas_valid on this first edge.
//   MEASURE, fall: hi_cap <= cnt.
//   MEASURE, rise: period <= cnt, high_time <= hi_cap, meas_valid <= 1 (next cycle, single
//    pulse), locked <= 1, cnt <= 1, stay MEASURE. Latency rise-detect -> meas_valid: 1 clk.
//   MEASURE, cnt == TIMEOUT and no rise this cycle: timeout <= 1 (one pulse), locked <= 0,
//    -> IDLE. period/high_time keep last values.
//  Simultaneous: rise on same cycle cnt==TIMEOUT -> treated as rise (valid, no timeout).
//  rise and fall can't coincide (single synchronized bit). Min measurable period = 2.
//  Input stuck low or high in IDLE: no outputs change, no timeout (timeout only from MEASURE).
//  Reset mid-measurement: everything cleared; first rise afterwards only re-arms (no valid).
//  Width: all arithmetic unsigned CNT_W; no wrap (saturation + timeout precede overflow).
// STRUCTURE
//  Package sigmeas_pkg: state enum {IDLE, MEASURE}, default CNT_W/TIMEOUT localparams.
//  Sub-module sync_edge_det (params SYNC_STAGES; ports clk, rst, d, q, rise, fall):
//   synchronizer + edge detector, reusable by other meters in the generator.
//  Top: counter, hi_cap register, FSM, output registers. All outputs registered.
// TESTING
//  1 Assert rst mid-run with sig_in toggling -> all outputs 0 immediately (async), state IDLE.
//  2 sig_in 512 high / 512 low, 4 periods -> first valid at 2nd rise; period=1024,
//    high_time=512, meas_valid 1-cycle pulses spaced 1024 clks, locked=1 after first valid.
//  3 Asymmetric 3 high / 5 low -> period=8, high_time=3; then switch to 1/1 -> period=2,
//    high_time=1 from the first full new period.
//  4 TIMEOUT=100, sig_in stuck low after lock -> timeout pulse exactly 100 clks after last
//    rise-detect cycle, locked=0, period/high_time unchanged; restart wave -> relock.
//  5 Rise arriving on the cycle cnt==TIMEOUT (period=TIMEOUT) -> meas_valid, period=TIMEOUT,
//    no timeout pulse.
//  6 Reset released mid-high phase of 20/20 wave -> no valid until second full rise;
//    then period=40, high_time=20.

Source files
------------

// File: rtl/sigmeas_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sigmeas_pkg
//  Purpose  : Shared types and defaults for the square-wave period meters.
//             Provides the meter state encoding and the default counter
//             width / loss-of-signal timeout.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sigmeas_pkg;

  // Meter state: IDLE waits for an arming rise, MEASURE times periods.
  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 65535;

endpackage : sigmeas_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module   : sync_edge_det
//  Purpose  : Brings an asynchronous level into the clk domain through a
//             SYNC_STAGES-deep flop chain, then flags its rising and falling
//             edges with one extra delay flop.
//  Ports    : clk  in  clock
//             rst  in  asynchronous active-high reset
//             d    in  asynchronous input level
//             q    out synchronized level
//             rise out one-cycle pulse on a 0->1 transition of q
//             fall out one-cycle pulse on a 1->0 transition of q
//  Revision : 1.0  initial release
// ============================================================================
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   q_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
      q_d    <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      q_d    <= sync_r[SYNC_STAGES-1];
    end
  end

  assign q    = sync_r[SYNC_STAGES-1];
  // A single synchronized bit cannot rise and fall in the same cycle.
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/square_period_meter.sv
`default_nettype none
// ============================================================================
//  Module   : square_period_meter
//  Purpose  : Measures period and high time (in clk cycles) of an incoming
//             square wave, strobes each completed period, and flags loss of
//             signal when no rising edge arrives within TIMEOUT cycles.
//  Ports    : clk        in  clock
//             rst        in  asynchronous active-high reset
//             sig_in     in  square wave, asynchronous to clk
//             period     out cycles between the last two rising edges
//             high_time  out cycles high within that period
//             meas_valid out one-cycle pulse when period/high_time update
//             locked     out at least one period measured, no timeout since
//             timeout    out one-cycle pulse on loss of signal
//  Revision : 1.0  initial release
// ============================================================================
module square_period_meter
  import sigmeas_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic             rise;
  logic             fall;
  logic             level_unused;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cap;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .q    (level_unused),
    .rise (rise),
    .fall (fall)
  );

  // cnt equals k on the k-th cycle after the rise cycle, so the value seen
  // on the next rise is the period and the value seen on the fall is the
  // high time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_cap     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          // First edge only arms the counter; no measurement yet.
          if (rise) begin
            state <= MEASURE;
            cnt   <= CNT_W'(1);
          end else begin
            cnt   <= '0;
          end
        end
        MEASURE: begin
          // A rise on the same cycle cnt reaches TIMEOUT wins over timeout.
          if (rise) begin
            period     <= cnt;
            high_time  <= hi_cap;
            meas_valid <= 1'b1;
            locked     <= 1'b1;
            cnt        <= CNT_W'(1);
          end else if (cnt == TIMEOUT_C) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (fall) begin
              hi_cap <= cnt;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule : square_period_meter
`default_nettype wire

// File: tb/tb_square_period_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_square_period_meter
//  Purpose  : Directed self-checking bench. One meter with default timeout,
//             one with TIMEOUT=100 for loss-of-signal scenarios; both share
//             the stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_square_period_meter;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in;

  logic [CNT_W-1:0] a_period, a_high;
  logic             a_valid, a_locked, a_timeout;
  logic [CNT_W-1:0] t_period, t_high;
  logic             t_valid, t_locked, t_timeout;

  int checks   = 0;
  int failures = 0;

  // Monitor counters (sampled on the falling edge).
  int cyc = 0;
  int a_vcnt = 0, a_last = 0, a_prev = 0, a_dbl = 0;
  int t_vcnt = 0, t_last = 0, t_tcnt = 0, t_tlast = 0;
  logic a_valid_d = 1'b0;

  always #5 clk = ~clk;

  square_period_meter #(
    .CNT_W (CNT_W), .TIMEOUT (65535), .SYNC_STAGES (2)
  ) dut (
    .clk (clk), .rst (rst), .sig_in (sig_in),
    .period (a_period), .high_time (a_high),
    .meas_valid (a_valid), .locked (a_locked), .timeout (a_timeout)
  );

  square_period_meter #(
    .CNT_W (CNT_W), .TIMEOUT (100), .SYNC_STAGES (2)
  ) dut_to (
    .clk (clk), .rst (rst), .sig_in (sig_in),
    .period (t_period), .high_time (t_high),
    .meas_valid (t_valid), .locked (t_locked), .timeout (t_timeout)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (a_valid) begin
      a_vcnt = a_vcnt + 1;
      a_prev = a_last;
      a_last = cyc;
      if (a_valid_d) a_dbl = a_dbl + 1;
    end
    a_valid_d = a_valid;
    if (t_valid) begin
      t_vcnt = t_vcnt + 1;
      t_last = cyc;
    end
    if (t_timeout) begin
      t_tcnt  = t_tcnt + 1;
      t_tlast = cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Hold sig_in at v for n cycles; changes land 1 time unit after posedge.
  task automatic drive(input logic v, input int n);
    sig_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  int v0, tc0;
  bit seen;

  initial begin
    rst    = 1'b1;
    sig_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_period",  32'(a_period), 0);
    check_eq("rst_high",    32'(a_high), 0);
    check_eq("rst_valid",   32'(a_valid), 0);
    check_eq("rst_locked",  32'(a_locked), 0);
    check_eq("rst_timeout", 32'(t_timeout), 0);
    rst = 1'b0;
    drive(1'b0, 5);

    // 512/512 toggle: five rises give four measurements.
    v0 = a_vcnt;
    wave(512, 512, 5);
    drive(1'b0, 10);
    check_eq("t2_nvalid",  32'(a_vcnt - v0), 4);
    check_eq("t2_period",  32'(a_period), 1024);
    check_eq("t2_high",    32'(a_high), 512);
    check_eq("t2_locked",  32'(a_locked), 1);
    check_eq("t2_spacing", 32'(a_last - a_prev), 1024);
    check_eq("t2_dblpulse", 32'(a_dbl), 0);

    // Asynchronous reset mid-run: outputs clear before any clock edge.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("t1_locked", 32'(a_locked), 0);
    check_eq("t1_period", 32'(a_period), 0);
    check_eq("t1_high",   32'(a_high), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 3);

    // Asymmetric 3/5, then fastest legal 1/1 wave.
    wave(3, 5, 6);
    drive(1'b0, 5);
    check_eq("t3_period_8", 32'(a_period), 8);
    check_eq("t3_high_3",   32'(a_high), 3);
    v0 = a_vcnt;
    wave(1, 1, 6);
    drive(1'b0, 5);
    check_eq("t3_nvalid",   32'(a_vcnt - v0), 6);
    check_eq("t3_period_2", 32'(a_period), 2);
    check_eq("t3_high_1",   32'(a_high), 1);
    check_eq("t3_dblpulse", 32'(a_dbl), 0);

    // Loss of signal on the TIMEOUT=100 meter.
    rst = 1'b1;
    drive(1'b0, 2);
    rst = 1'b0;
    drive(1'b0, 2);
    wave(10, 10, 4);
    check_eq("t4_locked_pre", 32'(t_locked), 1);
    check_eq("t4_period_pre", 32'(t_period), 20);
    tc0  = t_tcnt;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      drive(1'b0, 1);
      if (t_tcnt != tc0) seen = 1'b1;
    end
    check_eq("t4_timeout_seen", 32'(seen), 1);
    drive(1'b0, 200);
    check_eq("t4_timeout_once", 32'(t_tcnt - tc0), 1);
    check_eq("t4_timeout_delay", 32'(t_tlast - t_last), 100);
    check_eq("t4_locked_post", 32'(t_locked), 0);
    check_eq("t4_period_kept", 32'(t_period), 20);
    check_eq("t4_high_kept",   32'(t_high), 10);
    v0 = t_vcnt;
    wave(10, 10, 3);
    drive(1'b0, 5);
    check_eq("t4_relock_nvalid", 32'(t_vcnt - v0), 2);
    check_eq("t4_relock",        32'(t_locked), 1);

    // Rise landing exactly when cnt == TIMEOUT counts as a rise.
    v0  = t_vcnt;
    tc0 = t_tcnt;
    wave(50, 50, 3);
    check_eq("t5_no_timeout", 32'(t_tcnt - tc0), 0);
    check_eq("t5_nvalid",     32'(t_vcnt - v0), 3);
    check_eq("t5_period",     32'(t_period), 100);
    check_eq("t5_high",       32'(t_high), 50);
    check_eq("t5_locked",     32'(t_locked), 1);

    // Reset released during the high phase of a 20/20 wave.
    rst = 1'b1;
    drive(1'b1, 2);
    rst = 1'b0;
    v0 = a_vcnt;
    drive(1'b1, 10);
    drive(1'b0, 20);
    check_eq("t6_no_early_valid", 32'(a_vcnt - v0), 0);
    check_eq("t6_period_zero",    32'(a_period), 0);
    wave(20, 20, 3);
    drive(1'b0, 5);
    check_eq("t6_period", 32'(a_period), 40);
    check_eq("t6_high",   32'(a_high), 20);
    check_eq("t6_locked", 32'(a_locked), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_square_period_meter
`default_nettype wire
